// File: rtl/trace_commit_monitor.sv
// trace_commit_monitor: commit-trace monitor for the CPU.
// Watches 1..LANES retiring instructions per cycle and classifies each one as
// REG, STORE, NOP or HALT. It numbers each record and queues it in a FIFO with
// a registered first-word-fall-through head, drained through a valid/ready
// port. It also counts cycles and retired instructions, and stops on HALT.
// Optional build macro TRACE_WATCHDOG_EN: stop with timeout=1 once cycle_cnt
// reaches MAX_CYCLES. Without the macro, timeout is tied low.
module trace_commit_monitor #(
  parameter int DATA_W     = 16,
  parameter int REG_W      = 4,
  parameter int LANES      = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES-1:0]        commit_vld,
  input  logic [LANES*DATA_W-1:0] commit_pc,
  input  logic [LANES-1:0]        commit_reg_we,
  input  logic [LANES*REG_W-1:0]  commit_reg_idx,
  input  logic [LANES*DATA_W-1:0] commit_reg_data,
  input  logic [LANES-1:0]        commit_mem_rd,
  input  logic [LANES-1:0]        commit_mem_wr,
  input  logic [LANES*DATA_W-1:0] commit_mem_addr,
  input  logic [LANES*DATA_W-1:0] commit_mem_data,
  input  logic [LANES-1:0]        commit_halt,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [1:0]              rec_kind,
  output logic                    rec_load,
  output logic [CNT_W-1:0]        rec_inum,
  output logic [DATA_W-1:0]       rec_pc,
  output logic [REG_W-1:0]        rec_reg,
  output logic [DATA_W-1:0]       rec_addr,
  output logic [DATA_W-1:0]       rec_value,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic [CNT_W-1:0]        inst_cnt,
  output logic                    overflow,
  output logic                    halted,
  output logic                    timeout,
  output logic                    done
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {KIND_REG, KIND_STORE, KIND_NOP, KIND_HALT} kind_e;
  typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_TIMEOUT} state_e;

  typedef struct packed {
    logic [1:0]        kind;
    logic              load;
    logic [CNT_W-1:0]  inum;
    logic [DATA_W-1:0] pc;
    logic [REG_W-1:0]  rg;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] value;
  } rec_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Priority: register write, then halt, then store, else NOP.
  function automatic rec_t build_rec(
    input logic we, input logic rd, input logic wr, input logic hlt,
    input logic [DATA_W-1:0] pc, input logic [REG_W-1:0] idx,
    input logic [DATA_W-1:0] rdata, input logic [DATA_W-1:0] addr,
    input logic [DATA_W-1:0] mdata, input logic [CNT_W-1:0] inum);
    rec_t r;
    r      = '0;
    r.inum = inum;
    r.pc   = pc;
    if (we) begin
      r.kind  = KIND_REG;
      r.load  = rd;
      r.rg    = idx;
      r.addr  = rd ? addr : '0;
      r.value = rdata;
    end else if (hlt) begin
      r.kind = KIND_HALT;
    end else if (wr) begin
      r.kind  = KIND_STORE;
      r.addr  = addr;
      r.value = mdata;
    end else begin
      r.kind = KIND_NOP;
    end
    return r;
  endfunction

  // Lane view padded to two lanes; absent lanes read as idle.
  logic [1:0]        w_vld, w_we, w_rd, w_wr, w_halt;
  logic [DATA_W-1:0] w_pc [2];
  logic [DATA_W-1:0] w_rdata [2];
  logic [DATA_W-1:0] w_addr [2];
  logic [DATA_W-1:0] w_mdata [2];
  logic [REG_W-1:0]  w_idx [2];

  for (genvar gl = 0; gl < 2; gl++) begin : g_lane
    if (gl < LANES) begin : g_on
      assign w_vld[gl]   = commit_vld[gl];
      assign w_we[gl]    = commit_reg_we[gl];
      assign w_rd[gl]    = commit_mem_rd[gl];
      assign w_wr[gl]    = commit_mem_wr[gl];
      assign w_halt[gl]  = commit_halt[gl];
      assign w_pc[gl]    = commit_pc[gl*DATA_W +: DATA_W];
      assign w_rdata[gl] = commit_reg_data[gl*DATA_W +: DATA_W];
      assign w_addr[gl]  = commit_mem_addr[gl*DATA_W +: DATA_W];
      assign w_mdata[gl] = commit_mem_data[gl*DATA_W +: DATA_W];
      assign w_idx[gl]   = commit_reg_idx[gl*REG_W +: REG_W];
    end else begin : g_off
      assign w_vld[gl]   = 1'b0;
      assign w_we[gl]    = 1'b0;
      assign w_rd[gl]    = 1'b0;
      assign w_wr[gl]    = 1'b0;
      assign w_halt[gl]  = 1'b0;
      assign w_pc[gl]    = '0;
      assign w_rdata[gl] = '0;
      assign w_addr[gl]  = '0;
      assign w_mdata[gl] = '0;
      assign w_idx[gl]   = '0;
    end
  end

  state_e           r_state;
  logic             r_halted, r_timeout, r_overflow, r_valid;
  logic [CNT_W-1:0] r_cycle, r_inst;
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  rec_t             r_head;
  rec_t             r_mem [FIFO_DEPTH];

  logic             w_run, w_halt_now, w_fire, w_pop, w_drop;
  logic [1:0]       w_is_halt, w_proc, w_push, w_nproc, w_npush;
  logic [AW+1:0]    w_free;
  logic [AW-1:0]    w_wr_addr [2];
  logic [AW-1:0]    w_wptr_nxt, w_rptr_nxt;
  logic [AW:0]      w_count_nxt;
  rec_t             w_rec [2];
  rec_t             w_head_nxt;

  // A lane is a HALT only when it does not also write a register.
  assign w_is_halt  = ~w_we & w_halt;
  assign w_run      = (r_state == ST_RUN);
  assign w_proc[0]  = w_run & w_vld[0];
  assign w_proc[1]  = w_run & w_vld[1] & ~(w_proc[0] & w_is_halt[0]);
  assign w_halt_now = |(w_proc & w_is_halt);
  assign w_nproc    = {1'b0, w_proc[0]} + {1'b0, w_proc[1]};

`ifdef TRACE_WATCHDOG_EN
  assign w_fire = w_run & ~w_halt_now & (r_cycle >= CNT_W'(MAX_CYCLES));
`else
  assign w_fire = 1'b0;
`endif

  // A pop in this cycle frees a slot for a push in the same cycle.
  assign w_pop     = r_valid & rec_ready;
  assign w_free    = (AW+2)'(FIFO_DEPTH) - (AW+2)'(r_count) + (AW+2)'(w_pop);
  assign w_push[0] = w_proc[0] & (w_free != '0);
  assign w_push[1] = w_proc[1] & (w_free > (AW+2)'(w_push[0]));
  assign w_drop    = |(w_proc & ~w_push);
  assign w_npush   = {1'b0, w_push[0]} + {1'b0, w_push[1]};

  assign w_wr_addr[0] = r_wptr;
  assign w_wr_addr[1] = r_wptr + AW'(w_push[0]);
  assign w_wptr_nxt   = r_wptr + AW'(w_npush);
  assign w_rptr_nxt   = r_rptr + AW'(w_pop);
  assign w_count_nxt  = r_count - (AW+1)'(w_pop) + (AW+1)'(w_npush);

  // Build both lane records and pick the head that is visible after the edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    w_head_nxt = '0;
    w_rec[0] = build_rec(w_we[0], w_rd[0], w_wr[0], w_halt[0], w_pc[0], w_idx[0],
                         w_rdata[0], w_addr[0], w_mdata[0], r_inst);
    w_rec[1] = build_rec(w_we[1], w_rd[1], w_wr[1], w_halt[1], w_pc[1], w_idx[1],
                         w_rdata[1], w_addr[1], w_mdata[1], sat_add(r_inst, {1'b0, w_proc[0]}));
    if (w_count_nxt != '0) begin
      if (w_push[0] && (w_wr_addr[0] == w_rptr_nxt))      w_head_nxt = w_rec[0];
      else if (w_push[1] && (w_wr_addr[1] == w_rptr_nxt)) w_head_nxt = w_rec[1];
      else                                                w_head_nxt = r_mem[w_rptr_nxt];
    end
  end

  // Record storage, written in lane order.
  // NOTE: storage is not reset; r_count says which slots are valid and the head register is reset separately.
  always_ff @(posedge clk) begin
    if (w_push[0]) r_mem[w_wr_addr[0]] <= w_rec[0];
    if (w_push[1]) r_mem[w_wr_addr[1]] <= w_rec[1];
  end

  // FIFO pointers, occupancy, registered head and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_head     <= '0;
      r_overflow <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples pre-edge values.
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
      r_head  <= w_head_nxt;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Run/halt/timeout FSM with the counters it freezes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_halted  <= 1'b0;
      r_timeout <= 1'b0;
      r_cycle   <= '0;
      r_inst    <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_inst <= sat_add(r_inst, w_nproc);
          if (!w_fire) r_cycle <= sat_add(r_cycle, 2'd1);
          if (w_halt_now) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else if (w_fire) begin
            r_state   <= ST_TIMEOUT;
            r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rec_valid = r_valid;
  assign rec_kind  = r_head.kind;
  assign rec_load  = r_head.load;
  assign rec_inum  = r_head.inum;
  assign rec_pc    = r_head.pc;
  assign rec_reg   = r_head.rg;
  assign rec_addr  = r_head.addr;
  assign rec_value = r_head.value;
  assign cycle_cnt = r_cycle;
  assign inst_cnt  = r_inst;
  assign overflow  = r_overflow;
  assign halted    = r_halted;
  assign timeout   = r_timeout;
  assign done      = (r_halted | r_timeout) & ~r_valid;

endmodule

// File: tb/tb_trace_commit_monitor.sv
// Bench for trace_commit_monitor (two lanes, four-entry FIFO, MAX_CYCLES=20).
// Expected records go into a scoreboard queue when they are driven. The queue
// is compared against the FIFO head every cycle and popped on each handshake.
module tb_trace_commit_monitor;
  localparam int DW = 16, RW = 4, LN = 2, FD = 4, CW = 32, MC = 20;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [LN-1:0]        commit_vld, commit_reg_we, commit_mem_rd, commit_mem_wr, commit_halt;
  logic [LN*DW-1:0]     commit_pc, commit_reg_data, commit_mem_addr, commit_mem_data;
  logic [LN*RW-1:0]     commit_reg_idx;
  logic                 rec_valid, rec_ready, rec_load, overflow, halted, timeout, done;
  logic [1:0]           rec_kind;
  logic [CW-1:0]        rec_inum, cycle_cnt, inst_cnt;
  logic [DW-1:0]        rec_pc, rec_addr, rec_value;
  logic [RW-1:0]        rec_reg;

  always #5 clk = ~clk;

  trace_commit_monitor #(.DATA_W(DW), .REG_W(RW), .LANES(LN), .FIFO_DEPTH(FD),
                         .CNT_W(CW), .MAX_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n), .commit_vld(commit_vld), .commit_pc(commit_pc),
    .commit_reg_we(commit_reg_we), .commit_reg_idx(commit_reg_idx),
    .commit_reg_data(commit_reg_data), .commit_mem_rd(commit_mem_rd),
    .commit_mem_wr(commit_mem_wr), .commit_mem_addr(commit_mem_addr),
    .commit_mem_data(commit_mem_data), .commit_halt(commit_halt),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
    .rec_load(rec_load), .rec_inum(rec_inum), .rec_pc(rec_pc), .rec_reg(rec_reg),
    .rec_addr(rec_addr), .rec_value(rec_value), .cycle_cnt(cycle_cnt),
    .inst_cnt(inst_cnt), .overflow(overflow), .halted(halted), .timeout(timeout),
    .done(done));

  typedef struct packed {
    logic vld; logic [15:0] pc; logic we; logic [3:0] idx; logic [15:0] rdata;
    logic rd; logic wr; logic [15:0] addr; logic [15:0] mdata; logic halt;
  } lane_t;
  typedef struct packed {
    logic [1:0] kind; logic load; logic [15:0] pc; logic [3:0] rg;
    logic [15:0] addr; logic [15:0] value;
  } exp_t;
  typedef struct packed { lane_t l; exp_t e; } vec_t;

  logic [86:0] sb_q [$];
  logic [31:0] m_inst, m_cycles;
  bit          m_halt, m_to, m_ovf;
  int          n_checks = 0, n_fail = 0;
  lane_t       idle_l = '0;
  exp_t        idle_e = '0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [86:0] dut_rec();
    return {rec_kind, rec_load, rec_inum, rec_pc, rec_reg, rec_addr, rec_value};
  endfunction

  function automatic lane_t l_reg(input logic [15:0] pc, input logic [3:0] idx, input logic [15:0] d);
    lane_t l = '0;
    l.vld = 1'b1; l.pc = pc; l.we = 1'b1; l.idx = idx; l.rdata = d;
    return l;
  endfunction
  function automatic exp_t x_reg(input logic [15:0] pc, input logic [3:0] idx, input logic [15:0] d);
    exp_t e = '0;
    e.kind = 2'd0; e.pc = pc; e.rg = idx; e.value = d;
    return e;
  endfunction

  task automatic drive(input lane_t l0, input lane_t l1);
    commit_vld      = {l1.vld, l0.vld};
    commit_pc       = {l1.pc, l0.pc};
    commit_reg_we   = {l1.we, l0.we};
    commit_reg_idx  = {l1.idx, l0.idx};
    commit_reg_data = {l1.rdata, l0.rdata};
    commit_mem_rd   = {l1.rd, l0.rd};
    commit_mem_wr   = {l1.wr, l0.wr};
    commit_mem_addr = {l1.addr, l0.addr};
    commit_mem_data = {l1.mdata, l0.mdata};
    commit_halt     = {l1.halt, l0.halt};
  endtask

  task automatic model_push(input exp_t e);
    if (sb_q.size() < FD) sb_q.push_back({e.kind, e.load, m_inst, e.pc, e.rg, e.addr, e.value});
    else m_ovf = 1'b1;
    m_inst++;
  endtask

  // One clock: compare head, drive lanes, update the model, advance to edge+1.
  task automatic step(input lane_t l0, input exp_t e0, input lane_t l1, input exp_t e1, input bit rdy);
    bit hnow;
    check("rec_valid", rec_valid, sb_q.size() != 0);
    if (sb_q.size() != 0) begin
      check("rec_head", dut_rec(), sb_q[0]);
      if (rdy) void'(sb_q.pop_front());
    end
    drive(l0, l1);
    rec_ready = rdy;
    hnow = 1'b0;
    if (!m_halt && !m_to) begin
      if (l0.vld) begin model_push(e0); hnow = (e0.kind == 2'd3); end
      if (l1.vld && !hnow) begin model_push(e1); hnow = (e1.kind == 2'd3); end
`ifdef TRACE_WATCHDOG_EN
      if (!hnow && m_cycles >= MC) m_to = 1'b1;
      else m_cycles++;
`else
      m_cycles++;
`endif
      if (hnow) m_halt = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(idle_l, idle_e, idle_l, idle_e, rdy);
  endtask

  // Called at edge+1: asserts reset between edges and checks it took effect at once.
  task automatic do_reset();
    drive(idle_l, idle_l);
    rec_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", rec_valid, 0);
    check("rst_inst", inst_cnt, 0);
    check("rst_cycle", cycle_cnt, 0);
    check("rst_ovf", overflow, 0);
    check("rst_flags", {halted, timeout, done}, 0);
    check("rst_rec", dut_rec(), 0);
    #1 rst_n = 1'b1;
    sb_q.delete();
    m_inst = 0; m_cycles = 0; m_halt = 0; m_to = 0; m_ovf = 0;
  endtask

  task automatic chk_status(input string tag);
    check({tag, "_inst"}, inst_cnt, m_inst);
    check({tag, "_cycle"}, cycle_cnt, m_cycles);
    check({tag, "_ovf"}, overflow, m_ovf);
    check({tag, "_halted"}, halted, m_halt);
    check({tag, "_timeout"}, timeout, m_to);
    check({tag, "_done"}, done, (m_halt || m_to) && sb_q.size() == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    vec_t  tbl [4];
    lane_t l;
    exp_t  e;

    drive(idle_l, idle_l);
    rec_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();
    chk_status("init");

    // Reset with three records queued.
    for (int i = 0; i < 3; i++) step(l_reg(16'(i * 2), 4'(i), 16'h0050 + 16'(i)),
                                     x_reg(16'(i * 2), 4'(i), 16'h0050 + 16'(i)), idle_l, idle_e, 1'b0);
    chk_status("queued");
    do_reset();

    // Single lane, consumer always ready.
    tbl[0].l = l_reg(16'h0000, 4'd3, 16'h00AA);
    tbl[0].e = x_reg(16'h0000, 4'd3, 16'h00AA);
    tbl[1].l = '0; tbl[1].l.vld = 1; tbl[1].l.pc = 16'h0002; tbl[1].l.wr = 1;
    tbl[1].l.addr = 16'h0010; tbl[1].l.mdata = 16'h1234;
    tbl[1].e = '0; tbl[1].e.kind = 2'd1; tbl[1].e.pc = 16'h0002;
    tbl[1].e.addr = 16'h0010; tbl[1].e.value = 16'h1234;
    tbl[2].l = '0; tbl[2].l.vld = 1; tbl[2].l.pc = 16'h0004;
    tbl[2].e = '0; tbl[2].e.kind = 2'd2; tbl[2].e.pc = 16'h0004;
    tbl[3].l = '0; tbl[3].l.vld = 1; tbl[3].l.pc = 16'h0006; tbl[3].l.halt = 1;
    tbl[3].e = '0; tbl[3].e.kind = 2'd3; tbl[3].e.pc = 16'h0006;
    for (int i = 0; i < 4; i++) step(tbl[i].l, tbl[i].e, idle_l, idle_e, 1'b1);
    idle(2, 1'b1);
    step(l_reg(16'h0008, 4'd1, 16'h0001), x_reg(16'h0008, 4'd1, 16'h0001), idle_l, idle_e, 1'b1);
    chk_status("single");
    check("single_inst4", inst_cnt, 4);
    check("single_done", done, 1);

    // Load.
    do_reset();
    l = l_reg(16'h0100, 4'd5, 16'hBEEF); l.rd = 1; l.addr = 16'h0020;
    e = x_reg(16'h0100, 4'd5, 16'hBEEF); e.load = 1; e.addr = 16'h0020;
    step(l, e, idle_l, idle_e, 1'b0);
    check("load_kind", {rec_kind, rec_load, rec_addr, rec_value}, {2'd0, 1'b1, 16'h0020, 16'hBEEF});
    idle(2, 1'b1);
    chk_status("load");

    // Six commits into a four-entry FIFO with no consumer, then drain.
    do_reset();
    for (int i = 0; i < 6; i++) step(l_reg(16'(i * 2), 4'(i), 16'h0100 + 16'(i)),
                                     x_reg(16'(i * 2), 4'(i), 16'h0100 + 16'(i)), idle_l, idle_e, 1'b0);
    chk_status("ovf");
    check("ovf_set", overflow, 1);
    check("ovf_inst6", inst_cnt, 6);
    idle(5, 1'b1);
    chk_status("ovf_drain");

    // Dual push with one slot free, then push into a full FIFO during a pop.
    do_reset();
    for (int i = 0; i < 3; i++) step(l_reg(16'(i), 4'(i), 16'(i)), x_reg(16'(i), 4'(i), 16'(i)),
                                     idle_l, idle_e, 1'b0);
    step(l_reg(16'h0030, 4'd7, 16'h7777), x_reg(16'h0030, 4'd7, 16'h7777),
         l_reg(16'h0032, 4'd8, 16'h8888), x_reg(16'h0032, 4'd8, 16'h8888), 1'b0);
    check("dual_drop_ovf", overflow, 1);
    step(l_reg(16'h0040, 4'd9, 16'h9999), x_reg(16'h0040, 4'd9, 16'h9999), idle_l, idle_e, 1'b1);
    chk_status("popush");
    idle(5, 1'b1);

    // Two lanes: both retire, then HALT on lane 0 suppresses lane 1.
    do_reset();
    step(l_reg(16'h0200, 4'd1, 16'h0011), x_reg(16'h0200, 4'd1, 16'h0011), idle_l, idle_e, 1'b0);
    step(l_reg(16'h0202, 4'd2, 16'h0022), x_reg(16'h0202, 4'd2, 16'h0022),
         l_reg(16'h0204, 4'd3, 16'h0033), x_reg(16'h0204, 4'd3, 16'h0033), 1'b0);
    l = '0; l.vld = 1; l.pc = 16'h0206; l.halt = 1;
    e = '0; e.kind = 2'd3; e.pc = 16'h0206;
    step(l, e, l_reg(16'h0208, 4'd4, 16'h0044), x_reg(16'h0208, 4'd4, 16'h0044), 1'b0);
    chk_status("dual");
    check("dual_inst4", inst_cnt, 4);
    check("dual_halted", halted, 1);
    idle(5, 1'b1);
    chk_status("dual_drain");

    // Long run without HALT: the watchdog fires only when enabled.
    do_reset();
    for (int i = 0; i < 2; i++) step(l_reg(16'(i), 4'(i), 16'hA000 + 16'(i)),
                                     x_reg(16'(i), 4'(i), 16'hA000 + 16'(i)), idle_l, idle_e, 1'b0);
    idle(23, 1'b0);
    chk_status("wd");
`ifdef TRACE_WATCHDOG_EN
    check("wd_timeout", timeout, 1);
    check("wd_cycle20", cycle_cnt, 20);
    check("wd_notdone", done, 0);
`else
    check("wd_timeout", timeout, 0);
    check("wd_cycle25", cycle_cnt, 25);
`endif
    step(l_reg(16'h0300, 4'd6, 16'h0066), x_reg(16'h0300, 4'd6, 16'h0066), idle_l, idle_e, 1'b0);
    idle(4, 1'b1);
    chk_status("wd_drain");
`ifdef TRACE_WATCHDOG_EN
    check("wd_done", done, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/trace_commit_monitor.md
Name: trace_commit_monitor

Overview:
- Synthesizable commit-trace monitor for the CPU, parametrised in data width, FIFO depth and commit-lane count.
- Observes retiring instructions on 1..LANES commit lanes, classifies each as REG, STORE, NOP/branch or HALT, and numbers it.
- Buffers the resulting records in a FIFO drained through a valid/ready port.
- Tracks cycle and instruction counts, and stops cleanly on halt or on a cycle-limit timeout.

Parameters:
- DATA_W, 16: width of PC, register data, memory address and memory data.
- REG_W, 4: register index width.
- LANES, 1: commit lanes per cycle; legal values 1 or 2; lane 0 is the older instruction.
- FIFO_DEPTH, 8: record FIFO entries; power of two, 2..64.
- CNT_W, 32: width of the cycle and instruction counters.
- MAX_CYCLES, 1000: cycle limit for the watchdog.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- commit_vld  in  LANES  lane i retires an instruction this cycle
- commit_pc  in  LANES*DATA_W  PC per lane
- commit_reg_we  in  LANES  register write
- commit_reg_idx  in  LANES*REG_W  destination register
- commit_reg_data  in  LANES*DATA_W  register write data
- commit_mem_rd  in  LANES  load
- commit_mem_wr  in  LANES  store
- commit_mem_addr  in  LANES*DATA_W  memory address
- commit_mem_data  in  LANES*DATA_W  store data
- commit_halt  in  LANES  halt instruction
- rec_valid  out  1  FIFO head valid
- rec_ready  in  1  consumer accepts head
- rec_kind  out  2  0=REG, 1=STORE, 2=NOP, 3=HALT
- rec_load  out  1  REG record produced by a load
- rec_inum  out  CNT_W  instruction number
- rec_pc  out  DATA_W  PC
- rec_reg  out  REG_W  register index (REG records only)
- rec_addr  out  DATA_W  memory address (load/STORE records only)
- rec_value  out  DATA_W  register data or store data
- cycle_cnt  out  CNT_W  cycles counted in RUN
- inst_cnt  out  CNT_W  instructions retired
- overflow  out  1  sticky: a record was dropped
- halted  out  1  HALT retired
- timeout  out  1  watchdog fired
- done  out  1  (halted or timeout) and FIFO empty

Behaviour:
- Reset (async, rst_n=0): state=RUN; all counters 0; FIFO empty; rec_valid, overflow, halted, timeout and done all 0; record outputs 0.
- States:
  - RUN: cycle_cnt increments every cycle.
  - HALTED: counters frozen; commits ignored.
  - TIMEOUT: counters frozen; commits ignored.
- Classification per valid lane, in priority order:
  - reg_we gives REG; rec_load=mem_rd; rec_addr=mem_addr when loading, else 0.
  - else halt gives HALT.
  - else mem_wr gives STORE.
  - else NOP.
- rec_inum = inst_cnt value before the cycle's commits; lane 1 gets +1 when lane 0 is also valid. inst_cnt adds the number of valid lanes processed; the HALT commit itself is counted.
- HALT on lane 0 suppresses lane 1 that cycle. Any HALT moves RUN to HALTED at the next edge; halted=1.
- FIFO accounting:
  - Free slots = FIFO_DEPTH - occupancy + (rec_valid & rec_ready); a same-cycle pop frees a slot for a same-cycle push.
  - Records push in lane order.
  - A record with no free slot is dropped: overflow set (sticky until reset); inst_cnt still counts it.
- Drain handshake:
  - Head changes only on a pop (rec_valid & rec_ready).
  - Record outputs are registered (zero-latency FWFT): a record pushed at edge N is visible with rec_valid=1 after edge N when the FIFO was empty.
  - rec_valid stays high and fields stay stable while rec_ready=0.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is log2(FIFO_DEPTH)+1.
- Counters saturate at all-ones rather than wrapping.
- done asserts the cycle after the last record pops in HALTED/TIMEOUT; draining continues in both states.
- commit_* inputs are ignored while rst_n=0 and in HALTED/TIMEOUT.

Optional Feature:
- Macro TRACE_WATCHDOG_EN.
- When defined: in RUN, once cycle_cnt reaches MAX_CYCLES, the next edge sets timeout=1 and moves to TIMEOUT; a HALT in that same cycle takes priority (HALTED, timeout stays 0).
- When undefined: TIMEOUT is unreachable, timeout is tied to 0, and cycle_cnt runs until it saturates.

Test Plan:
- Reset mid-stream: 3 records queued, rst_n low for 1 cycle -> rec_valid=0, inst_cnt=0, cycle_cnt=0, overflow=0 immediately (asynchronous), without waiting for a clock edge.
- Single lane, rec_ready=1: REG r3=0x00AA at PC 0x0000, STORE 0x1234 to 0x0010, NOP, HALT at PC 0x0006 -> records (0,REG,r3,0x00AA), (1,STORE,0x0010,0x1234), (2,NOP), (3,HALT,0x0006); inst_cnt=4; done=1.
- Load: reg_we=1, mem_rd=1, addr 0x0020, data 0xBEEF -> REG, rec_load=1, rec_addr=0x0020, rec_value=0xBEEF.
- FIFO_DEPTH=4, rec_ready=0, 6 commits -> first 4 retained in order, overflow=1, inst_cnt=6; raising rec_ready drains inum 0..3.
- LANES=2: both lanes valid with 3 slots free, then HALT on lane 0 with lane 1 valid -> inum n, n+1 in lane order; lane 1 dropped with no record; halted=1.
- TRACE_WATCHDOG_EN defined, MAX_CYCLES=20, no HALT -> timeout=1 after cycle 20; cycle_cnt frozen at 20; done=1 once the FIFO drains.
